// File: rtl/vt_rng_pkg.sv
// Shared types and constants for the V-trapezoid RNG sequencer/arbiter.
// The seed guards replace an all-zero seed, which would lock up the LFSR.
package vt_rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [23:0] SEED_DEFAULT  = 24'h000001;
    localparam logic [15:0] SEED2_DEFAULT = 16'h0001;
    localparam int          RNG_PIPE_LAT  = 4;

    function automatic logic [23:0] guard_seed(input logic [23:0] s);
        return (s == 24'h000000) ? SEED_DEFAULT : s;
    endfunction

    function automatic logic [15:0] guard_seed2(input logic [15:0] s);
        return (s == 16'h0000) ? SEED2_DEFAULT : s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr,
// searching cyclically; reports the one-hot pick, its index and whether any bit was set.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    logic [PW-1:0] w_j;

    // cyclic scan from the pointer; the first hit wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_j]) begin
                o_any         = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/vt_rng_sched.sv
// Sequencer and round-robin arbiter for one V-trapezoid RNG: seeds and resets the
// RNG, masks its pipeline during warm-up, then hands each sample to one requester.
module vt_rng_sched
    import vt_rng_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int XW            = 12,
    parameter int WARMUP        = 8,
    parameter int SEED_CYC      = 2,
    parameter int RESEED_PERIOD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [23:0]     seed_in,
    input  logic [15:0]     seed2_in,
    input  logic            seed_load,
    output logic            rng_reset_n,
    output logic [23:0]     rng_data,
    output logic [15:0]     rng_data2,
    input  logic [XW-1:0]   rng_x,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [XW-1:0]   out_data,
    output logic            out_valid,
    output logic            rng_ready,
    output logic [31:0]     sample_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    logic [31:0]     r_cnt;
    logic [31:0]     r_since_seed;
    logic [31:0]     r_sample_cnt;
    logic [PW-1:0]   r_rr_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [XW-1:0]   r_out_data;
    logic            r_out_valid;
    logic            r_rng_ready;
    logic            r_rng_reset_n;
    logic [23:0]     r_rng_data;
    logic [15:0]     r_rng_data2;

    logic [NREQ-1:0] w_onehot;
    logic [PW-1:0]   w_idx;
    logic            w_any;
    logic            w_grant;
    logic            w_reseed_hit;
    logic            w_enter_seed;
    logic [PW-1:0]   w_ptr_next;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // grant / reseed decisions; seed_load suppresses the grant for its own cycle
    always_comb begin
        w_grant      = (r_state == RUN) && !seed_load && w_any;
        w_reseed_hit = (RESEED_PERIOD != 0) && ((r_since_seed + 32'd1) == 32'(RESEED_PERIOD));
        w_enter_seed = (r_state == IDLE) || seed_load || (w_grant && w_reseed_hit);
        if (w_idx == PW'(NREQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_idx + PW'(1);
        end
    end

    // sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SEED;
            r_cnt         <= 32'd0;
            r_since_seed  <= 32'd0;
            r_rng_reset_n <= 1'b0;
            r_rng_data    <= SEED_DEFAULT;
            r_rng_data2   <= SEED2_DEFAULT;
            r_gnt         <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_rng_ready   <= 1'b0;
            r_sample_cnt  <= 32'd0;
            r_rr_ptr      <= '0;
        end else if (!enable) begin
            r_state       <= IDLE;
            r_cnt         <= 32'd0;
            r_rng_reset_n <= 1'b0;
            r_gnt         <= '0;
            r_out_valid   <= 1'b0;
            r_rng_ready   <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            if (w_grant) begin
                r_gnt        <= w_onehot;
                r_out_valid  <= 1'b1;
                r_out_data   <= rng_x;
                r_sample_cnt <= r_sample_cnt + 32'd1;
                r_rr_ptr     <= w_ptr_next;
                r_since_seed <= r_since_seed + 32'd1;
            end
            // a reseed still delivers the grant above, then restarts seeding
            if (w_enter_seed) begin
                r_state       <= SEED;
                r_cnt         <= 32'd0;
                r_since_seed  <= 32'd0;
                r_rng_reset_n <= 1'b0;
                r_rng_ready   <= 1'b0;
                r_rng_data    <= guard_seed(seed_in);
                r_rng_data2   <= guard_seed2(seed2_in);
            end else begin
                case (r_state)
                    SEED: begin
                        if (r_cnt == 32'(SEED_CYC - 1)) begin
                            r_state       <= FILL;
                            r_cnt         <= 32'd0;
                            r_rng_reset_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    FILL: begin
                        if (r_cnt == 32'(WARMUP - 1)) begin
                            r_state     <= RUN;
                            r_cnt       <= 32'd0;
                            r_rng_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    RUN: begin
                        r_rng_ready <= 1'b1;
                    end
                    default: begin
                        r_state       <= IDLE;
                        r_rng_reset_n <= 1'b0;
                        r_rng_ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rng_reset_n = r_rng_reset_n;
    assign rng_data    = r_rng_data;
    assign rng_data2   = r_rng_data2;
    assign gnt         = r_gnt;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign rng_ready   = r_rng_ready;
    assign sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_vt_rng_sched.sv
// Scoreboard bench: two instances (reseed disabled / RESEED_PERIOD=3); stimulus pushes
// expected grants, per-instance monitors pop and compare whenever out_valid is seen.
module tb_vt_rng_sched;

    typedef struct {
        logic [3:0]  g;
        logic [11:0] d;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        enable2 = 1'b0;
    logic [23:0] seed_in = 24'hABCDEF;
    logic [15:0] seed2_in = 16'h1234;
    logic        seed_load = 1'b0;
    logic        seed_load2 = 1'b0;
    logic [11:0] rng_x = 12'h000;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  req2 = 4'b0000;

    logic        rng_reset_n, rng_reset_n2;
    logic [23:0] rng_data, rng_data_2;
    logic [15:0] rng_data2, rng_data2_2;
    logic [3:0]  gnt, gnt2;
    logic [11:0] out_data, out_data2;
    logic        out_valid, out_valid2;
    logic        rng_ready, rng_ready2;
    logic [31:0] sample_cnt, sample_cnt2;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    vt_rng_sched u_dut (
        .clk(clk), .reset(reset), .enable(enable), .seed_in(seed_in), .seed2_in(seed2_in),
        .seed_load(seed_load), .rng_reset_n(rng_reset_n), .rng_data(rng_data),
        .rng_data2(rng_data2), .rng_x(rng_x), .req(req), .gnt(gnt), .out_data(out_data),
        .out_valid(out_valid), .rng_ready(rng_ready), .sample_cnt(sample_cnt)
    );

    vt_rng_sched #(.RESEED_PERIOD(3)) u_dut_rs (
        .clk(clk), .reset(reset), .enable(enable2), .seed_in(seed_in), .seed2_in(seed2_in),
        .seed_load(seed_load2), .rng_reset_n(rng_reset_n2), .rng_data(rng_data_2),
        .rng_data2(rng_data2_2), .rng_x(rng_x), .req(req2), .gnt(gnt2), .out_data(out_data2),
        .out_valid(out_valid2), .rng_ready(rng_ready2), .sample_cnt(sample_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [3:0] g, input logic [11:0] d, input logic [31:0] c);
        q1.push_back(exp_t'{g, d, c});
    endtask

    task automatic push2(input logic [3:0] g, input logic [11:0] d, input logic [31:0] c);
        q2.push_back(exp_t'{g, d, c});
    endtask

    // called right after the edge that entered SEED on u_dut
    task automatic seed_fill1(input logic [23:0] exp_seed, input logic [15:0] exp_seed2);
        chk("seed_entry_rstn", rng_reset_n, 0);
        chk("seed_entry_data", rng_data, exp_seed);
        chk("seed_entry_data2", rng_data2, exp_seed2);
        chk("seed_entry_ready", rng_ready, 0);
        tick();
        chk("seed_rstn_low2", rng_reset_n, 0);
        tick();
        chk("fill_rstn_high", rng_reset_n, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("fill_ready", rng_ready, 32'(i == 8));
        end
        chk("seed_hold_data", rng_data, exp_seed);
    endtask

    task automatic chk_reset_vals();
        chk("rst_rstn", rng_reset_n, 0);
        chk("rst_data", rng_data, 24'h000001);
        chk("rst_data2", rng_data2, 16'h0001);
        chk("rst_gnt", gnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", rng_ready, 0);
        chk("rst_cnt", sample_cnt, 0);
    endtask

    // scoreboard monitor for u_dut
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected_gnt1", gnt, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("gnt1", gnt, e.g);
                chk("data1", out_data, e.d);
                chk("cnt1", sample_cnt, e.c);
            end
        end
    end

    // scoreboard monitor for u_dut_rs
    always @(negedge clk) begin
        if (out_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("unexpected_gnt2", gnt2, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("gnt2", gnt2, e.g);
                chk("data2", out_data2, e.d);
                chk("cnt2", sample_cnt2, e.c);
            end
        end
    end

    initial begin
        // reset, then bring-up with reset-time default seeds
        tick();
        tick();
        chk_reset_vals();
        reset = 1'b0;
        enable = 1'b1;
        seed_fill1(24'h000001, 16'h0001);

        // all requesters held: strict rotation
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rng_x = 12'h100 + 12'(k);
            push1(4'(1 << (k % 4)), rng_x, 32'(k + 1));
            tick();
        end
        req = 4'b0000;
        chk("cnt_after_rotation", sample_cnt, 8);

        // pointer behaviour: 0100, then 1001 twice, then 0001 wraps from ptr 1
        req = 4'b0100; rng_x = 12'h200; push1(4'b0100, rng_x, 9);  tick();
        req = 4'b1001; rng_x = 12'h201; push1(4'b1000, rng_x, 10); tick();
        rng_x = 12'h202; push1(4'b0001, rng_x, 11); tick();
        req = 4'b0001; rng_x = 12'h203; push1(4'b0001, rng_x, 12); tick();
        req = 4'b0000; rng_x = 12'hFFF;
        tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_hold_data", out_data, 12'h203);
        chk("idle_cnt", sample_cnt, 12);

        // seed_load with zero seeds in RUN: no grant, guarded seeds
        seed_load = 1'b1; seed_in = 24'h000000; seed2_in = 16'h0000; req = 4'b1111;
        tick();
        seed_load = 1'b0; seed_in = 24'h123456; req = 4'b0000;
        seed_fill1(24'h000001, 16'h0001);
        req = 4'b1111;
        rng_x = 12'h2A0; push1(4'b0010, rng_x, 13); tick();
        rng_x = 12'h2A1; push1(4'b0100, rng_x, 14); tick();
        req = 4'b0000;

        // reseed with real seeds, drop enable mid-FILL, restart from IDLE
        seed_load = 1'b1; seed_in = 24'hABCDEF; seed2_in = 16'h2468;
        tick();
        seed_load = 1'b0;
        chk("reseed_data", rng_data, 24'hABCDEF);
        chk("reseed_data2", rng_data2, 16'h2468);
        tick();
        tick();
        chk("reseed_fill_rstn", rng_reset_n, 1);
        tick(); tick(); tick();
        enable = 1'b0;
        tick();
        chk("idle_rstn", rng_reset_n, 0);
        chk("idle_ready", rng_ready, 0);
        tick();
        chk("idle_stay_rstn", rng_reset_n, 0);
        enable = 1'b1; seed_in = 24'h00FF00; seed2_in = 16'h00AA;
        tick();
        seed_fill1(24'h00FF00, 16'h00AA);
        req = 4'b1111;
        rng_x = 12'h2B0; push1(4'b1000, rng_x, 15); tick();
        rng_x = 12'h2B1; push1(4'b0001, rng_x, 16); tick();

        // reset mid-RUN with requests pending
        reset = 1'b1;
        tick();
        chk_reset_vals();
        reset = 1'b0; enable = 1'b0; req = 4'b0000;
        tick();

        // auto-reseed instance: 3 grants, reseed from current seed_in, resume after 2+8
        enable2 = 1'b1; seed_in = 24'h5A5A5A; seed2_in = 16'hBEEF; req2 = 4'b0001;
        tick();
        chk("rs_seed_data", rng_data_2, 24'h5A5A5A);
        chk("rs_seed_data2", rng_data2_2, 16'hBEEF);
        chk("rs_seed_rstn", rng_reset_n2, 0);
        tick();
        tick();
        chk("rs_fill_rstn", rng_reset_n2, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rs_fill_ready", rng_ready2, 32'(i == 8));
        end
        seed_in = 24'h0C0C0C;
        for (int k = 0; k < 3; k++) begin
            rng_x = 12'h300 + 12'(k);
            push2(4'b0001, rng_x, 32'(k + 1));
            tick();
        end
        chk("rs_after3_ready", rng_ready2, 0);
        chk("rs_after3_rstn", rng_reset_n2, 0);
        chk("rs_after3_data", rng_data_2, 24'h0C0C0C);
        tick();
        tick();
        chk("rs_refill_rstn", rng_reset_n2, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rs_refill_ready", rng_ready2, 32'(i == 8));
        end
        rng_x = 12'h3AA; push2(4'b0001, rng_x, 4); tick();
        req2 = 4'b0000;
        tick();
        tick();
        chk("rs_final_cnt", sample_cnt2, 4);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
